router_iact_mc: RTL and testbench
=================================

Name: router_iact_mc

Overview:
- Multicast input-activation router. Streams a programmable-length block of iact words from the GLB into the iact scratchpads of up to NUM_PE processing elements in one pass.
- Successor to the single-PE fixed-length iact loader. Adds a runtime base address and length, a PE destination mask, per-PE backpressure and a parametrised GLB read latency.
- Sits between the GLB iact bank and a PE row, and is commanded by the cluster control unit.

Parameters:
- DATA_BITWIDTH, 16, iact word width.
- ADDR_BITWIDTH_GLB, 10, GLB address width.
- LEN_BITWIDTH, 10, width of the transfer-length field.
- NUM_PE, 3, number of destination spads.
- GLB_RD_LATENCY, 1, cycles from read_req_glb_iact to valid r_data_glb_iact (allowed range 1..4).
- FIFO_DEPTH, GLB_RD_LATENCY+2, internal reorder/skid buffer depth.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_BITWIDTH_GLB  first GLB address; latched on start.
- xfer_len  in  LEN_BITWIDTH  number of words to move; latched on start.
- pe_mask  in  NUM_PE  destination PE set; latched on start.
- r_data_glb_iact  in  DATA_BITWIDTH  GLB read data.
- r_addr_glb_iact  out  ADDR_BITWIDTH_GLB  GLB read address.
- read_req_glb_iact  out  1  GLB read strobe, one word per asserted cycle.
- w_data_spad  out  DATA_BITWIDTH  word broadcast to all spads.
- load_en_spad  out  NUM_PE  per-PE write strobe.
- spad_ready  in  NUM_PE  per-PE ready to accept a word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FIFO is emptied, all counters cleared, in-flight pipeline valids cleared, state = IDLE.
  - A reset mid-transfer aborts it: in-flight GLB data is discarded and done is not pulsed.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- busy = (state != IDLE); done = (state == DONE).
- IDLE:
  - start=1 latches base_addr, xfer_len and pe_mask.
  - xfer_len==0 goes directly to DONE (no reads, no writes); otherwise goes to STREAM.
- STREAM:
  - Asserts read_req_glb_iact in any cycle where credits > 0, with credits = FIFO_DEPTH - fifo_count - inflight.
  - Each issued read increments r_addr_glb_iact, wrapping modulo 2^ADDR_BITWIDTH_GLB, and decrements the remaining-read counter.
  - After the read with remaining==1 issues, goes to DRAIN.
- DRAIN: waits for inflight==0 and an empty FIFO, then goes to DONE.
- DONE: lasts 1 cycle, then returns to IDLE.
- start asserted while busy is ignored.
- GLB return path:
  - A GLB_RD_LATENCY-deep valid shift register tracks issued reads.
  - When its tail is 1, r_data_glb_iact is pushed into the FIFO on that edge.
  - The credit scheme guarantees a push never finds the FIFO full. An overflow is a design error and the bench asserts against it.
- Spad write path:
  - Combinational from the FIFO head: fire = !empty && ((spad_ready & mask) == mask).
  - On fire: load_en_spad = mask, w_data_spad = head, and the head pops.
  - Otherwise load_en_spad = 0 and w_data_spad holds the last value.
  - Multicast is all-or-nothing: a word is never written to a subset of the masked PEs.
- mask==0: fire reduces to !empty, so words are drained and discarded (load_en stays 0) and done still pulses.
- Same-cycle push and pop are allowed; fifo_count is unchanged.
- Words are delivered in address order.
- Throughput with all ready high is 1 word per cycle in steady state.
- Latency from start to first load_en is GLB_RD_LATENCY+2 cycles.
- Last write to done is 1 cycle.

Decomposition:
- Package router_pkg holds:
  - the state enum;
  - a function computing FIFO_DEPTH from GLB_RD_LATENCY;
  - the pointer-width helper ($clog2).
- Sub-module iact_fifo (synchronous, parametrised width/depth, count output, push/pop same cycle) holds the buffer. The FSM, credit logic and latency pipe remain in router_iact_mc.

Test Plan:
- Basic single-PE transfer:
  - Stimulus: base=100, len=25, mask=3'b001, ready=all 1, latency 1.
  - Required: reads to addresses 100..124 on consecutive cycles; 25 writes with data equal to GLB contents in order; done exactly 1 cycle after the 25th write; busy falls with done.
- Multicast with backpressure:
  - Stimulus: mask=3'b101, spad_ready[2] low for cycles 5..12.
  - Required: no load_en during the stall; read_req stops once credits reach 0; no FIFO overflow; all words delivered to PE0 and PE2 identically; load_en_spad[1] is never set.
- Zero length and ignored start:
  - Stimulus: len=0.
  - Required: done on the cycle after start; read_req and load_en are never asserted.
  - Stimulus: a second start while busy.
  - Required: the second start is ignored.
- Address wrap:
  - Stimulus: base=1020, len=8.
  - Required: addresses 1020, 1021, 1022, 1023, 0, 1, 2, 3.
- Reset mid-operation:
  - Stimulus: assert reset after 10 writes of a 25-word transfer.
  - Required: all outputs 0 on the next cycle; no done pulse; a new start with base=0, len=4 completes correctly.
- Latency sweep:
  - Stimulus: GLB_RD_LATENCY = 2 and 4, len=16, ready=all 1.
  - Required: first write at start+L+2; 16 back-to-back writes; data correct.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state type and sizing helpers for the multicast iact router
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Two extra slots cover one word popping and one word landing in the same cycle.
    function automatic int fifo_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iact_fifo.sv
// rtl/iact_fifo.sv - synchronous FIFO with occupancy count, same-cycle push and pop
module iact_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int CNT_W = ptr_width(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/router_iact_mc.sv
// rtl/router_iact_mc.sv - multicast iact router: GLB block reads broadcast to a masked set of PE spads
module router_iact_mc
    import router_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int LEN_BITWIDTH      = 10,
    parameter int NUM_PE            = 3,
    parameter int GLB_RD_LATENCY    = 1,
    parameter int FIFO_DEPTH        = fifo_depth(GLB_RD_LATENCY)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_BITWIDTH_GLB-1:0] base_addr,
    input  logic [LEN_BITWIDTH-1:0]      xfer_len,
    input  logic [NUM_PE-1:0]            pe_mask,
    input  logic [DATA_BITWIDTH-1:0]     r_data_glb_iact,
    output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_iact,
    output logic                         read_req_glb_iact,
    output logic [DATA_BITWIDTH-1:0]     w_data_spad,
    output logic [NUM_PE-1:0]            load_en_spad,
    input  logic [NUM_PE-1:0]            spad_ready,
    output logic                         busy,
    output logic                         done
);
    localparam int CNT_W = ptr_width(FIFO_DEPTH + 1);

    state_t                       state_q, state_d;
    logic [ADDR_BITWIDTH_GLB-1:0] addr_q, addr_d;
    logic [LEN_BITWIDTH-1:0]      rem_q, rem_d;
    logic [NUM_PE-1:0]            mask_q, mask_d;
    logic [GLB_RD_LATENCY-1:0]    vpipe_q, vpipe_d;
    logic [DATA_BITWIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_BITWIDTH-1:0]     fifo_head;
    logic [CNT_W-1:0]             fifo_count, inflight;
    logic [CNT_W:0]               occupied;
    logic                         fifo_empty, issue, fire, push;

    iact_fifo #(
        .WIDTH (DATA_BITWIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (r_data_glb_iact),
        .pop       (fire),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < GLB_RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vpipe_q[i]);
        end
        // A read is only issued if its word is guaranteed a FIFO slot when it lands.
        occupied = {1'b0, fifo_count} + {1'b0, inflight};
        issue    = (state_q == ST_STREAM) && (occupied < (CNT_W + 1)'(FIFO_DEPTH));
        push     = vpipe_q[GLB_RD_LATENCY-1];
        vpipe_d  = (vpipe_q << 1) | GLB_RD_LATENCY'(issue);
        fire     = !fifo_empty && ((spad_ready & mask_q) == mask_q);
        wdata_d  = fire ? fifo_head : wdata_q;

        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = xfer_len;
                    mask_d  = pe_mask;
                    state_d = (xfer_len == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_BITWIDTH_GLB'(1);
                    rem_d  = rem_q - LEN_BITWIDTH'(1);
                    if (rem_q == LEN_BITWIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as the last word pops so done follows the final write by one cycle.
                if (inflight == '0 && (fifo_empty || (fifo_count == CNT_W'(1) && fire))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            mask_q  <= '0;
            vpipe_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            vpipe_q <= vpipe_d;
            wdata_q <= wdata_d;
        end
    end

    assign r_addr_glb_iact   = addr_q;
    assign read_req_glb_iact = issue;
    assign w_data_spad       = wdata_d;
    assign load_en_spad      = fire ? mask_q : '0;
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);

endmodule

// File: tb/tb_router_iact_mc.sv
// tb/tb_router_iact_mc.sv - bench for router_iact_mc at GLB read latencies 1, 2 and 4
module tb_router_iact_mc;
    localparam int NI = 3;
    localparam int LAT [NI] = '{1, 2, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [9:0]  base_addr, xfer_len;
    logic [2:0]  pe_mask, spad_ready;
    logic [15:0] r_data [NI];
    logic [9:0]  r_addr [NI];
    logic        read_req [NI];
    logic [15:0] w_data [NI];
    logic [2:0]  load_en [NI];
    logic        busy [NI];
    logic        done [NI];
    logic [9:0]  gaddr [NI][4];
    logic [3:0]  gval [NI];

    function automatic logic [15:0] glb(input logic [9:0] a);
        return 16'h5A00 ^ {a[5:0], a};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        router_iact_mc #(.GLB_RD_LATENCY(LAT[g])) u_dut (
            .clk               (clk),
            .reset             (reset),
            .start             (start),
            .base_addr         (base_addr),
            .xfer_len          (xfer_len),
            .pe_mask           (pe_mask),
            .r_data_glb_iact   (r_data[g]),
            .r_addr_glb_iact   (r_addr[g]),
            .read_req_glb_iact (read_req[g]),
            .w_data_spad       (w_data[g]),
            .load_en_spad      (load_en[g]),
            .spad_ready        (spad_ready),
            .busy              (busy[g]),
            .done              (done[g])
        );
        assign r_data[g] = gval[g][LAT[g]-1] ? glb(gaddr[g][LAT[g]-1]) : 16'hBAD0;
    end

    // GLB memory: data for a read appears exactly LAT cycles after its request.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            gval[i]     <= {gval[i][2:0], read_req[i]};
            gaddr[i][0] <= r_addr[i];
            for (int j = 1; j < 4; j++) gaddr[i][j] <= gaddr[i][j-1];
        end
    end

    int n_vec = 0, n_err = 0, cyc = 0;
    int phase [NI];
    int kc [NI], rd [NI], wr [NI];
    int m_base [NI], m_len [NI], m_mask [NI];
    bit m_exact [NI];
    bit exact_in;
    int pin_a0 [NI], pin_a4 [NI], pin_first [NI], pin_done [NI];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lat%0d cyc%0d: got %0h want %0h", nm, LAT[i], cyc, act, exp);
        end
    endtask

    // phase: 0 idle, 1 transfer running, 2 first cycle after reset, 3 before any reset
    initial begin
        for (int i = 0; i < NI; i++) phase[i] = 3;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (phase[i] == 2) begin
                    chk("rst_busy", i, busy[i], 0);
                    chk("rst_done", i, done[i], 0);
                    chk("rst_rdreq", i, read_req[i], 0);
                    chk("rst_loaden", i, load_en[i], 0);
                    chk("rst_raddr", i, r_addr[i], 0);
                    chk("rst_wdata", i, w_data[i], 0);
                end
                if (reset) begin
                    phase[i] = 2;
                end else begin
                    if (phase[i] == 2) phase[i] = 0;
                    if (phase[i] == 1) begin
                        kc[i]++;
                        chk("busy", i, busy[i], 1);
                        if (m_exact[i]) chk("rd_timing", i, read_req[i], kc[i] >= 1 && kc[i] <= m_len[i]);
                        if (read_req[i]) begin
                            chk("rd_addr", i, r_addr[i], (m_base[i] + rd[i]) % 1024);
                            chk("rd_count", i, rd[i] < m_len[i], 1);
                            if (rd[i] == 0 && pin_a0[i] >= 0) chk("pin_addr0", i, r_addr[i], pin_a0[i]);
                            if (rd[i] == 4 && pin_a4[i] >= 0) chk("pin_addr4", i, r_addr[i], pin_a4[i]);
                            rd[i]++;
                        end
                        if (m_exact[i])
                            chk("wr_timing", i, load_en[i] != 0,
                                m_mask[i] != 0 && kc[i] >= LAT[i] + 2 && kc[i] <= LAT[i] + 1 + m_len[i]);
                        if (load_en[i] != 0) begin
                            chk("wr_mask", i, load_en[i], m_mask[i]);
                            chk("wr_ready", i, (spad_ready & 3'(m_mask[i])) == 3'(m_mask[i]), 1);
                            chk("wr_data", i, w_data[i], glb(10'((m_base[i] + wr[i]) % 1024)));
                            chk("wr_count", i, wr[i] < m_len[i], 1);
                            if (wr[i] == 0 && pin_first[i] >= 0) chk("pin_first_wr", i, kc[i], pin_first[i]);
                            wr[i]++;
                        end
                        if (m_mask[i] != 0) chk("occupancy", i, (rd[i] - wr[i]) <= LAT[i] + 2, 1);
                        if (m_exact[i])
                            chk("done_timing", i, done[i], kc[i] == ((m_len[i] == 0) ? 1 : LAT[i] + 2 + m_len[i]));
                        if (done[i]) begin
                            chk("done_reads", i, rd[i], m_len[i]);
                            if (m_mask[i] != 0) chk("done_writes", i, wr[i], m_len[i]);
                            if (pin_done[i] >= 0) chk("pin_done", i, kc[i], pin_done[i]);
                            phase[i] = 0;
                        end else if (kc[i] > 3000) begin
                            chk("timeout", i, 0, 1);
                            phase[i] = 0;
                        end
                    end else if (phase[i] == 0) begin
                        chk("idle_busy", i, busy[i], 0);
                        chk("idle_done", i, done[i], 0);
                        chk("idle_rdreq", i, read_req[i], 0);
                        chk("idle_loaden", i, load_en[i], 0);
                        if (start) begin
                            phase[i]   = 1;
                            kc[i]      = 0;
                            rd[i]      = 0;
                            wr[i]      = 0;
                            m_base[i]  = int'(base_addr);
                            m_len[i]   = int'(xfer_len);
                            m_mask[i]  = int'(pe_mask);
                            m_exact[i] = exact_in;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pins();
        pin_a0    = '{-1, -1, -1};
        pin_a4    = '{-1, -1, -1};
        pin_first = '{-1, -1, -1};
        pin_done  = '{-1, -1, -1};
    endtask

    task automatic go(input int b, input int l, input logic [2:0] m, input bit ex);
        base_addr = 10'(b);
        xfer_len  = 10'(l);
        pe_mask   = m;
        exact_in  = ex;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 4000; n++) begin
            if (phase[0] == 0 && phase[1] == 0 && phase[2] == 0) break;
            tick();
        end
        tick();
        clear_pins();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; xfer_len = '0;
        pe_mask = '0; spad_ready = 3'b111; exact_in = 1'b0;
        clear_pins();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // single PE, with a second start while busy that must be ignored
        pin_a0 = '{100, 100, 100}; pin_a4 = '{104, 104, 104};
        pin_first = '{3, 4, 6}; pin_done = '{28, 29, 31};
        go(100, 25, 3'b001, 1'b1);
        repeat (4) tick();
        base_addr = 10'd500; xfer_len = 10'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();

        // multicast to PE0/PE2 with PE2 stalled for cycles 5..12
        go(200, 20, 3'b101, 1'b0);
        for (int k = 1; k < 40; k++) begin
            spad_ready = (k >= 5 && k <= 12) ? 3'b011 : 3'b111;
            tick();
        end
        spad_ready = 3'b111;
        wait_idle();

        // all PEs with one of them ready only every other cycle
        go(600, 12, 3'b111, 1'b0);
        for (int k = 1; k < 60; k++) begin
            spad_ready = (k % 2 == 1) ? 3'b111 : 3'b110;
            tick();
        end
        spad_ready = 3'b111;
        wait_idle();

        pin_done = '{1, 1, 1};
        go(7, 0, 3'b001, 1'b1);
        wait_idle();

        pin_a0 = '{1020, 1020, 1020}; pin_a4 = '{0, 0, 0}; pin_done = '{11, 12, 14};
        go(1020, 8, 3'b111, 1'b1);
        wait_idle();

        pin_done = '{9, 10, 12};
        go(50, 6, 3'b000, 1'b1);
        wait_idle();

        // abort after ten writes, then a fresh short transfer
        go(300, 25, 3'b111, 1'b1);
        for (int n = 0; n < 200; n++) begin
            if (wr[0] >= 10) break;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        pin_a0 = '{0, 0, 0}; pin_done = '{7, 8, 10};
        go(0, 4, 3'b011, 1'b1);
        wait_idle();

        pin_first = '{3, 4, 6}; pin_done = '{19, 20, 22};
        go(400, 16, 3'b111, 1'b1);
        wait_idle();

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
